div_seq_radix2: RTL and testbench

Multi-cycle 32-bit integer divider that answers the execute-stage ALU's divide requests for DIV/DIVU. The ALU raises `start_i` and stalls the pipeline until this block pulses `ready_o`. At that point `result_o` carries {remainder, quotient} for the HI/LO write. It uses radix-2 restoring division, one quotient bit per clock, and supports signed and unsigned operands plus pipeline flush/annul.

---
 rtl/div_seq_radix2_if.sv | 33 +++
 rtl/div_seq_radix2.sv | 129 ++++++++++++
 tb/tb_div_seq_radix2.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_radix2_if.sv
// Request/response bundle between the execute-stage ALU and the divider.
// The ALU drives the request side; the divider drives ready/result.
interface div_seq_radix2_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;

  modport master (
    output start_i,
    output annul_i,
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    input  ready_o,
    input  result_o
  );

  modport slave (
    input  start_i,
    input  annul_i,
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    output ready_o,
    output result_o
  );
endinterface

// File: rtl/div_seq_radix2.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// result_o = {remainder, quotient}, ready_o is a one-cycle pulse.
module div_seq_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  div_seq_radix2_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DZERO,
    DONE
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     div_q;
  logic                 qneg_q;
  logic                 rneg_q;
  logic                 ready_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 kill;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       rem_sh;
  logic                 ge;
  logic [WIDTH-1:0]     rem_d;
  logic [WIDTH-1:0]     quo_d;
  logic [WIDTH-1:0]     q_fin;
  logic [WIDTH-1:0]     r_fin;

  assign kill = flush | bus.annul_i;

  always_comb begin
    a_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    b_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    a_mag = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    b_mag = b_neg ? -bus.opdata2_i : bus.opdata2_i;
  end

  // rem < divisor always holds, so WIDTH bits suffice after each step
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, div_q};
    rem_d  = ge ? (rem_sh[WIDTH-1:0] - div_q) : rem_sh[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], ge};
    q_fin  = qneg_q ? -quo_d : quo_d;
    r_fin  = rneg_q ? -rem_d : rem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          if (bus.start_i && !kill) begin
            if (bus.opdata2_i == '0) begin
              state_q <= DZERO;
            end else begin
              rem_q   <= '0;
              quo_q   <= a_mag;
              div_q   <= b_mag;
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              cnt_q   <= '0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (kill) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              result_q <= {r_fin, q_fin};
              ready_q  <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DZERO: begin
          if (kill) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_div_seq_radix2.sv
// Scoreboard bench for div_seq_radix2: directed cases plus a random
// sweep checked against a plain-arithmetic reference model.
module tb_div_seq_radix2;
  logic clk = 1'b0;
  logic rst;
  logic flush;

  div_seq_radix2_if #(.WIDTH(32)) bus ();

  div_seq_radix2 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic        prev_rdy = 1'b0;
  logic [63:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready_o pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy <= 1'b0;
    end else begin
      if (bus.ready_o) begin
        n_cmp++;
        if (prev_rdy) begin
          n_err++;
          $display("FAIL ready_width: ready_o high for more than one cycle at cyc %0d", cyc);
        end else if (sb.size() == 0) begin
          n_err++;
          $display("FAIL spurious_ready: got ready_o with result %h, required no pulse", bus.result_o);
        end else begin
          e = sb.pop_front();
          if (bus.result_o !== e.res || (cyc - e.t0) != e.lat) begin
            n_err++;
            $display("FAIL result: got %h latency %0d, required %h latency %0d",
                     bus.result_o, cyc - e.t0, e.res, e.lat);
          end
        end
      end
      prev_rdy <= bus.ready_o;
    end
  end

  function automatic logic [63:0] model(logic [31:0] a, logic [31:0] b, logic sg);
    longint na, nb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'd0, a});
      nb = longint'({32'd0, b});
    end
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge idle again
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic sg, input logic [63:0] expv,
                       input bit chg);
    bit got;
    exp_t x;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sg;
    bus.start_i      = 1'b1;
    x.res = expv;
    x.lat = (b == 32'd0) ? 2 : 33;
    x.t0  = cyc;
    sb.push_back(x);
    last_res = expv;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (chg && i == 5) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sg;
      end
      if (bus.ready_o) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: no ready_o for %h / %h, required %h", a, b, expv);
      sb.delete();
    end
    bus.start_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_kill(input int at, input bit use_annul);
    bus.opdata1_i    = 32'd12345;
    bus.opdata2_i    = 32'd17;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    repeat (at) @(negedge clk);
    if (use_annul) bus.annul_i = 1'b1;
    else flush = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    flush       = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (bus.result_o !== last_res) begin
      n_err++;
      $display("FAIL kill_hold: result_o %h, required %h", bus.result_o, last_res);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sg;
    rst              = 1'b1;
    flush            = 1'b0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: ready_o %b, required 0", bus.ready_o);
    end
    n_cmp++;
    if (bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL reset_result: result_o %h, required 0", bus.result_o);
    end
    rst = 1'b0;
    @(negedge clk);

    do_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    do_op(32'hFFFF_FFFF, 32'd2, 1'b0, {32'h0000_0001, 32'h7FFF_FFFF}, 1'b0);
    do_op(32'd1234, 32'd0, 1'b0, 64'd0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 1'b0);
    do_kill(10, 1'b0);
    do_op(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 1'b0);
    do_kill(20, 1'b1);
    do_op(32'd1000, 32'hFFFF_FFFD, 1'b1, {32'h0000_0001, 32'hFFFF_FEB3}, 1'b1);

    bus.opdata1_i    = 32'd999;
    bus.opdata2_i    = 32'd4;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
      n_err++;
      $display("FAIL mid_reset: ready_o %b result_o %h, required 0 and 0",
               bus.ready_o, bus.result_o);
    end
    rst = 1'b0;
    last_res = 64'd0;
    repeat (40) @(negedge clk);

    for (int n = 0; n < 2000; n++) begin
      a  = pick();
      b  = pick();
      sg = 1'($urandom_range(0, 1));
      do_op(a, b, sg, model(a, b, sg), 1'b0);
    end

    repeat (5) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected responses never seen, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
